// File: rtl/cory_repeat_sched_if.sv
// Handshake bundle between M command/data producers, the repeat scheduler and one z consumer.
// The slave modport is the scheduler's view; the master modport is the producer/consumer side.
interface cory_repeat_sched_if #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int IW = 2
);
    logic [M-1:0]   i_cmd_v;
    logic [M*W-1:0] i_cmd_cnt;
    logic [M-1:0]   o_cmd_r;
    logic [M-1:0]   i_a_v;
    logic [M*N-1:0] i_a_d;
    logic [M-1:0]   o_a_r;
    logic           o_z_v;
    logic [N-1:0]   o_z_d;
    logic           o_z_last;
    logic [W-1:0]   o_z_cnt;
    logic [IW-1:0]  o_z_id;
    logic           i_z_r;

    modport slave (
        input  i_cmd_v, i_cmd_cnt, i_a_v, i_a_d, i_z_r,
        output o_cmd_r, o_a_r, o_z_v, o_z_d, o_z_last, o_z_cnt, o_z_id
    );

    modport master (
        output i_cmd_v, i_cmd_cnt, i_a_v, i_a_d, i_z_r,
        input  o_cmd_r, o_a_r, o_z_v, o_z_d, o_z_last, o_z_cnt, o_z_id
    );
endinterface

// File: rtl/cory_repeat_sched.sv
// Round-robin shared repeat engine: grants one requester, replays its data word cnt times on z.
// Define CORY_REPEAT_SCHED_B2B_EN to re-arbitrate on the last beat for zero-bubble bursts.
module cory_repeat_sched #(
    parameter int M  = 4,
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic                clk,
    input  logic                reset,
    cory_repeat_sched_if.slave  s_bus
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state, w_state_next;
    logic [IW-1:0] r_gnt_id, w_gnt_id_next;
    logic [W-1:0]  r_gnt_cnt, w_gnt_cnt_next;
    logic [W-1:0]  r_cnt, w_cnt_next;
    logic [IW-1:0] r_ptr, w_ptr_next;

    logic [W-1:0]  w_req_cnt [M];
    logic [N-1:0]  w_req_d   [M];
    logic [M-1:0]  w_gnt_oh;
    logic [M-1:0]  w_win_oh;

    logic [IW-1:0] w_arb_start;
    logic [M-1:0]  w_arb_req;
    logic [IW-1:0] w_scan_id [M];
    logic          w_arb_found;
    logic [IW-1:0] w_arb_id;
    logic          w_arb_en;

    logic          w_busy;
    logic          w_zv;
    logic          w_last_beat;
    logic          w_hs;

    function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] id);
        if (id == IW'(M - 1)) return '0;
        return id + IW'(1);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_req
            assign w_req_cnt[gi] = s_bus.i_cmd_cnt[gi*W +: W];
            assign w_req_d[gi]   = s_bus.i_a_d[gi*N +: N];
            assign w_gnt_oh[gi]  = (r_gnt_id == IW'(gi));
            assign w_win_oh[gi]  = w_arb_found && (w_arb_id == IW'(gi));
        end

        // Offset gi from the scan start, wrapped modulo M rather than 2^IW.
        for (gi = 0; gi < M; gi++) begin : g_scan
            logic [IW:0] w_sum;
            assign w_sum = {1'b0, w_arb_start} + (IW+1)'(gi);
            assign w_scan_id[gi] = (w_sum >= (IW+1)'(M)) ? IW'(w_sum - (IW+1)'(M))
                                                         : w_sum[IW-1:0];
        end
    endgenerate

    assign w_busy      = (r_state == ST_BUSY);
    assign w_zv        = w_busy && s_bus.i_a_v[r_gnt_id];
    assign w_last_beat = (r_cnt == r_gnt_cnt - W'(1));
    assign w_hs        = w_zv && s_bus.i_z_r;

`ifdef CORY_REPEAT_SCHED_B2B_EN
    assign w_arb_en    = !w_busy || (w_hs && w_last_beat);
    assign w_arb_start = w_busy ? f_inc(r_gnt_id) : r_ptr;
    assign w_arb_req   = w_busy ? (s_bus.i_cmd_v & ~w_gnt_oh) : s_bus.i_cmd_v;
`else
    assign w_arb_en    = !w_busy;
    assign w_arb_start = r_ptr;
    assign w_arb_req   = s_bus.i_cmd_v;
`endif

    // Walk offsets from far to near so the nearest requester from the start wins.
    always_comb begin
        w_arb_found = 1'b0;
        w_arb_id    = '0;
        for (int i = M - 1; i >= 0; i--) begin
            if (w_arb_req[w_scan_id[i]]) begin
                w_arb_found = 1'b1;
                w_arb_id    = w_scan_id[i];
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_gnt_id_next  = r_gnt_id;
        w_gnt_cnt_next = r_gnt_cnt;
        w_cnt_next     = r_cnt;
        w_ptr_next     = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_gnt_id_next  = w_arb_id;
                    w_gnt_cnt_next = w_req_cnt[w_arb_id];
                    w_cnt_next     = '0;
                    if (w_req_cnt[w_arb_id] == '0) begin
                        w_ptr_next = f_inc(w_arb_id);
                    end else begin
                        w_state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (w_hs) begin
                    if (w_last_beat) begin
                        w_cnt_next   = '0;
                        w_ptr_next   = f_inc(r_gnt_id);
                        w_state_next = ST_IDLE;
`ifdef CORY_REPEAT_SCHED_B2B_EN
                        if (w_arb_found) begin
                            w_gnt_id_next  = w_arb_id;
                            w_gnt_cnt_next = w_req_cnt[w_arb_id];
                            if (w_req_cnt[w_arb_id] == '0) begin
                                w_ptr_next = f_inc(w_arb_id);
                            end else begin
                                w_state_next = ST_BUSY;
                            end
                        end
`endif
                    end else begin
                        w_cnt_next = r_cnt + W'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_gnt_id  <= '0;
            r_gnt_cnt <= '0;
            r_cnt     <= '0;
            r_ptr     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_gnt_id  <= w_gnt_id_next;
            r_gnt_cnt <= w_gnt_cnt_next;
            r_cnt     <= w_cnt_next;
            r_ptr     <= w_ptr_next;
        end
    end

    // Accept is combinational off i_cmd_v, so it is held low while reset is asserted.
    assign s_bus.o_cmd_r  = (w_arb_en && !reset) ? w_win_oh : '0;
    assign s_bus.o_a_r    = (w_hs && w_last_beat) ? w_gnt_oh : '0;
    assign s_bus.o_z_v    = w_zv;
    assign s_bus.o_z_d    = w_zv ? w_req_d[r_gnt_id] : '0;
    assign s_bus.o_z_last = w_busy && w_last_beat;
    assign s_bus.o_z_cnt  = w_busy ? r_cnt : '0;
    assign s_bus.o_z_id   = r_gnt_id;

endmodule

// File: tb/tb_cory_repeat_sched.sv
// Self-checking bench for cory_repeat_sched: arbitration table, scoreboarded bursts and corner sequences.
module tb_cory_repeat_sched;
    localparam int M  = 4;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 2;
    localparam int W4 = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [N-1:0]  data;
        logic [W-1:0]  idx;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [M-1:0] cmd_v;
        logic [M-1:0] exp_cmd_r;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cory_repeat_sched_if #(.M(M), .N(N), .W(W),  .IW(IW)) bus ();
    cory_repeat_sched_if #(.M(M), .N(N), .W(W4), .IW(IW)) bus4 ();

    cory_repeat_sched #(.M(M), .N(N), .W(W), .IW(IW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .s_bus (bus)
    );

    cory_repeat_sched #(.M(M), .N(N), .W(W4), .IW(IW)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .s_bus (bus4)
    );

    int errors = 0;
    int checks = 0;

    logic [W-1:0] rq_cnt [M][4];
    logic [N-1:0] rq_dat [M][4];
    int           rq_len [M];
    int           rq_pos [M];
    logic [N-1:0] cur_d  [M];
    logic [M-1:0] busy_q;
    logic [M-1:0] stall;
    beat_t        sbq[$];
    int           gq[$];
    int           zr_pat[$];
    int           cyc, first_acc_cyc, last_ar_cyc, hs_count;
    vec_t         vec [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic add_cmd(input int k, input int cnt, input int data);
        rq_cnt[k][rq_len[k]] = W'(cnt);
        rq_dat[k][rq_len[k]] = N'(data);
        rq_len[k]++;
    endtask

    task automatic drive();
        logic pend;
        for (int k = 0; k < M; k++) begin
            pend = (rq_pos[k] < rq_len[k]) && !busy_q[k];
            bus.i_cmd_v[k]         = pend;
            bus.i_cmd_cnt[k*W +: W] = pend ? rq_cnt[k][rq_pos[k]] : '0;
            bus.i_a_v[k]           = (pend || busy_q[k]) && !stall[k];
            bus.i_a_d[k*N +: N]    = busy_q[k] ? cur_d[k] : (pend ? rq_dat[k][rq_pos[k]] : '0);
        end
    endtask

    function automatic bit work_left();
        for (int k = 0; k < M; k++) if (rq_pos[k] < rq_len[k]) return 1'b1;
        return (sbq.size() != 0) || (busy_q != '0);
    endfunction

    // One clock: sample and score at the falling edge, then update requesters after the rising edge.
    task automatic cycle();
        logic [M-1:0] acc, arr, exp_ar;
        beat_t b;
        int gid, c;
        @(negedge clk);
        acc = bus.o_cmd_r;
        arr = bus.o_a_r;
        if (!bus.o_z_v) chk("z_d_gated", bus.o_z_d, 0);
        if (bus.o_z_v && bus.i_z_r) begin
            hs_count++;
            $display("beat id=%0d data=%02h cnt=%0d last=%0b", bus.o_z_id, bus.o_z_d, bus.o_z_cnt, bus.o_z_last);
            if (sbq.size() == 0) begin
                chk("unexpected_beat", 64'(sbq.size()), 1);
            end else begin
                b = sbq.pop_front();
                exp_ar = b.last ? (M'(1) << b.id) : '0;
                chk("beat_id",   bus.o_z_id,   b.id);
                chk("beat_data", bus.o_z_d,    b.data);
                chk("beat_cnt",  bus.o_z_cnt,  b.idx);
                chk("beat_last", bus.o_z_last, b.last);
                chk("a_r",       arr,          exp_ar);
            end
        end else begin
            chk("a_r_no_beat", arr, 0);
        end
        if (acc != '0) begin
            $display("grant o_cmd_r=%04b", acc);
            if (gq.size() == 0) begin
                chk("unexpected_grant", acc, 0);
            end else begin
                gid = gq.pop_front();
                chk("grant", acc, M'(1) << gid);
            end
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        if (arr != '0) last_ar_cyc = cyc;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < M; k++) if (arr[k]) busy_q[k] = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (acc[k] && rq_pos[k] < rq_len[k]) begin
                c = int'(rq_cnt[k][rq_pos[k]]);
                for (int i = 0; i < c; i++) begin
                    b.id   = IW'(k);
                    b.data = rq_dat[k][rq_pos[k]];
                    b.idx  = W'(i);
                    b.last = (i == c - 1);
                    sbq.push_back(b);
                end
                if (c != 0) begin
                    busy_q[k] = 1'b1;
                    cur_d[k]  = rq_dat[k][rq_pos[k]];
                end
                rq_pos[k]++;
            end
        end
        bus.i_z_r = (zr_pat.size() > 0 && busy_q != '0) ? 1'(zr_pat.pop_front()) : 1'b1;
        drive();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (work_left() && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) chk({name, "_timeout"}, 64'(n), 64'(budget - 1));
        cycle();
        cycle();
        chk({name, "_grants_left"}, 64'(gq.size()), 0);
    endtask

    task automatic clear_agents();
        for (int k = 0; k < M; k++) begin
            rq_len[k] = 0;
            rq_pos[k] = 0;
            cur_d[k]  = '0;
        end
        busy_q = '0;
        stall  = '0;
        sbq.delete();
        gq.delete();
        zr_pat.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_agents();
        drive();
        bus.i_z_r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        first_acc_cyc = -1;
        last_ar_cyc   = -1;
        hs_count      = 0;
    endtask

    initial begin
        int n, beats;
        bit drop;
        reset = 1'b1;
        cyc = 0;
        clear_agents();
        drive();
        bus.i_z_r      = 1'b1;
        bus4.i_cmd_v   = '0;
        bus4.i_cmd_cnt = '0;
        bus4.i_a_v     = '0;
        bus4.i_a_d     = '0;
        bus4.i_z_r     = 1'b0;

        vec[0] = '{4'b0000, 4'b0000};
        vec[1] = '{4'b1010, 4'b0010};
        vec[2] = '{4'b1010, 4'b1000};
        vec[3] = '{4'b1001, 4'b0001};
        vec[4] = '{4'b0001, 4'b0001};
        vec[5] = '{4'b1111, 4'b0010};
        vec[6] = '{4'b0110, 4'b0100};
        vec[7] = '{4'b0111, 4'b0001};
        vec[8] = '{4'b1100, 4'b0100};
        vec[9] = '{4'b1000, 4'b1000};

        // Reset state, with requests pending that must not be accepted.
        bus.i_cmd_v = 4'b1111;
        #12;
        chk("rst_cmd_r",  bus.o_cmd_r,  0);
        chk("rst_a_r",    bus.o_a_r,    0);
        chk("rst_z_v",    bus.o_z_v,    0);
        chk("rst_z_d",    bus.o_z_d,    0);
        chk("rst_z_last", bus.o_z_last, 0);
        chk("rst_z_cnt",  bus.o_z_cnt,  0);
        chk("rst_z_id",   bus.o_z_id,   0);
        do_reset();

        // Arbitration table: zero-count commands, rotating pointer and modulo-M wrap.
        bus.i_cmd_cnt = '0;
        bus.i_a_v     = '0;
        for (int i = 0; i < 10; i++) begin
            bus.i_cmd_v = vec[i].cmd_v;
            @(negedge clk);
            $display("arb row=%0d cmd_v=%04b o_cmd_r=%04b", i, vec[i].cmd_v, bus.o_cmd_r);
            chk("arb_cmd_r", bus.o_cmd_r, vec[i].exp_cmd_r);
            chk("arb_z_v",   bus.o_z_v,   0);
            chk("arb_a_r",   bus.o_a_r,   0);
            @(posedge clk);
            #1;
        end
        bus.i_cmd_v = '0;

        // Single requester burst.
        do_reset();
        add_cmd(2, 3, 8'hA5);
        gq.push_back(2);
        drive();
        drain("single", 50);
        chk("single_latency", 64'(last_ar_cyc - first_acc_cyc), 3);
        chk("single_beats", 64'(hs_count), 3);

        // All requesters busy: rotation and inter-burst spacing.
        do_reset();
        add_cmd(0, 2, 8'h10);
        add_cmd(0, 2, 8'h14);
        add_cmd(1, 2, 8'h11);
        add_cmd(2, 2, 8'h12);
        add_cmd(3, 2, 8'h13);
        gq = '{0, 1, 2, 3, 0};
        drive();
        drain("rotate", 200);
`ifdef CORY_REPEAT_SCHED_B2B_EN
        chk("rotate_span", 64'(last_ar_cyc - first_acc_cyc), 10);
`else
        chk("rotate_span", 64'(last_ar_cyc - first_acc_cyc), 14);
`endif
        chk("rotate_beats", 64'(hs_count), 10);

        // Backpressure on the z stream.
        do_reset();
        add_cmd(1, 4, 8'h3C);
        gq.push_back(1);
        zr_pat = '{1, 0, 0, 1, 1, 0, 1};
        drive();
        drain("bp", 100);
        chk("bp_beats", 64'(hs_count), 4);
        chk("bp_span", 64'(last_ar_cyc - first_acc_cyc), 7);

        // Zero-count winner followed by a single-beat burst.
        do_reset();
        add_cmd(1, 0, 8'h99);
        add_cmd(3, 1, 8'h77);
        gq = '{1, 3};
        drive();
        drain("zero", 50);
        chk("zero_beats", 64'(hs_count), 1);
        chk("zero_span", 64'(last_ar_cyc - first_acc_cyc), 2);

        // Data stall mid-burst, then reset while busy.
        do_reset();
        add_cmd(2, 5, 8'h5A);
        gq.push_back(2);
        drive();
        n = 0;
        while (hs_count < 2 && n < 50) begin
            cycle();
            n++;
        end
        chk("stall_reach_two", 64'(hs_count), 2);
        stall[2] = 1'b1;
        add_cmd(0, 1, 8'h11);
        add_cmd(3, 1, 8'h33);
        drive();
        repeat (3) begin
            @(negedge clk);
            chk("stall_z_v",   bus.o_z_v,   0);
            chk("stall_z_d",   bus.o_z_d,   0);
            chk("stall_z_cnt", bus.o_z_cnt, 2);
            chk("stall_cmd_r", bus.o_cmd_r, 0);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        chk("midrst_cmd_r",  bus.o_cmd_r,  0);
        chk("midrst_a_r",    bus.o_a_r,    0);
        chk("midrst_z_v",    bus.o_z_v,    0);
        chk("midrst_z_d",    bus.o_z_d,    0);
        chk("midrst_z_last", bus.o_z_last, 0);
        chk("midrst_z_cnt",  bus.o_z_cnt,  0);
        chk("midrst_z_id",   bus.o_z_id,   0);
        sbq.delete();
        busy_q    = '0;
        stall     = '0;
        rq_pos[2] = rq_len[2];
        gq.delete();
        gq = '{0, 3};
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        hs_count = 0;
        drain("post_rst", 50);
        chk("post_rst_beats", 64'(hs_count), 2);

        // Maximum count on the 4-bit-count instance.
        bus4.i_cmd_v   = 4'b0001;
        bus4.i_cmd_cnt = 16'h000F;
        bus4.i_a_v     = 4'b0001;
        bus4.i_a_d     = 32'h0000_00C3;
        bus4.i_z_r     = 1'b1;
        beats = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drop = bus4.o_cmd_r[0];
            if (bus4.o_z_v && bus4.i_z_r) begin
                $display("max beat cnt=%0d last=%0b", bus4.o_z_cnt, bus4.o_z_last);
                chk("max_cnt",  bus4.o_z_cnt,  64'(beats));
                chk("max_data", bus4.o_z_d,    8'hC3);
                chk("max_last", bus4.o_z_last, 64'(beats == 14));
                chk("max_a_r",  bus4.o_a_r,    (beats == 14) ? 1 : 0);
                beats++;
            end else begin
                chk("max_a_r_idle", bus4.o_a_r, 0);
            end
            @(posedge clk);
            #1;
            if (drop) bus4.i_cmd_v = '0;
        end
        chk("max_beats", 64'(beats), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cory_repeat_sched.md
Name: cory_repeat_sched

Overview:
- Shares one repeat engine among M requesters. Each requester presents a repeat command (count) plus one data word.
- Round-robin arbitration picks one requester and locks the grant for the whole burst. The block replays that requester's data word cnt times on a single z stream, then releases.
- Sits between several command/data producers and one downstream consumer of repeated data.

Parameters:
- M, 4, number of requesters (2..16)
- N, 8, data width
- W, 8, repeat-count width
- IW, 2, requester-id width (must be at least clog2(M))

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- i_cmd_v  in  M  per-requester command valid
- i_cmd_cnt  in  M*W  per-requester repeat count; requester k uses bits [k*W +: W]; 0 means zero beats
- o_cmd_r  out  M  per-requester command accept (one-hot pulse)
- i_a_v  in  M  per-requester data valid
- i_a_d  in  M*N  per-requester data, packed the same way as i_cmd_cnt
- o_a_r  out  M  per-requester data consume (one-hot pulse on the last beat)
- o_z_v  out  1  output valid
- o_z_d  out  N  output data
- o_z_last  out  1  last beat of the burst
- o_z_cnt  out  W  beat index within the burst, 0-based
- o_z_id  out  IW  id of the granted requester
- i_z_r  in  1  output ready

Behaviour:
- States: IDLE and BUSY. Registers: state, gnt_id, gnt_cnt (W bits), beat counter cnt (W bits), round-robin pointer ptr (IW bits).
- Reset (asynchronous, any time, including mid-burst):
  - state=IDLE; gnt_id, gnt_cnt, cnt and ptr all 0.
  - All outputs 0. The in-flight burst is abandoned and no o_a_r is issued for it.
- IDLE, arbitration:
  - Winner = first k with i_cmd_v[k]=1, scanning ptr, ptr+1, ... and wrapping modulo M.
  - In the same cycle: o_cmd_r[k]=1; gnt_id<=k; gnt_cnt<=i_cmd_cnt[k]; cnt<=0.
  - Command accept is a single-cycle pulse, whether or not i_a_v[k] is set.
- IDLE, zero count: if the winner's count is 0, accept the command and stay IDLE. o_a_r is not pulsed, no z beat is emitted, and ptr<=k+1 (mod M).
- IDLE, non-zero count: state<=BUSY. Minimum latency from i_cmd_v to the first o_z_v is 1 cycle.
- BUSY, output mux:
  - o_z_v = i_a_v[gnt_id]; o_z_d = i_a_d[gnt_id]; o_z_id = gnt_id; o_z_cnt = cnt.
  - o_z_last = (cnt == gnt_cnt-1).
  - o_z_d is 0 whenever o_z_v is 0.
- BUSY, beat handshake: a beat transfers when o_z_v & i_z_r.
  - Not last: cnt<=cnt+1.
  - Last: o_a_r[gnt_id]=1 for that cycle; cnt<=0; ptr<=gnt_id+1 (mod M); state<=IDLE.
- While BUSY:
  - o_cmd_r is all 0, and requests from other requesters wait.
  - Changes to the granted requester's i_cmd_cnt are ignored, because the count is latched.
  - If i_a_v[gnt_id] drops, o_z_v drops and cnt holds.
- Grant order: with all requesters continuously requesting, grants rotate k, k+1, ... and each requester gets exactly one burst per rotation.
- Width rules:
  - cnt never exceeds gnt_cnt-1.
  - gnt_cnt = 2^W-1 gives the maximum burst; cnt wraps to 0 only via the last-beat rule.
  - The ptr increment wraps modulo M, not 2^IW.
- Outputs in IDLE: o_z_v=0, o_a_r=0, o_z_last=0, o_z_cnt=0, o_z_id=gnt_id.
- Throughput without the optional feature: one IDLE cycle between bursts.

Optional Feature:
- Macro: CORY_REPEAT_SCHED_B2B_EN.
- Defined: on the last-beat handshake in BUSY, arbitration runs in the same cycle.
  - Candidates exclude gnt_id; the scan starts at gnt_id+1.
  - The winner gets its o_cmd_r pulse in that cycle, and gnt_id, gnt_cnt and cnt are reloaded.
  - State remains BUSY if the new count is non-zero. The result is zero-bubble back-to-back bursts.
  - A zero-count winner is accepted and state goes to IDLE.
- Not defined: every burst returns to IDLE, giving the one-cycle bubble.

Test Plan:
- Single requester, M=4: i_cmd_v[2]=1, cnt=3, data 0xA5, i_z_r=1. Expect o_cmd_r[2] pulse at T0. At T1..T3: o_z_v=1, o_z_d=0xA5, o_z_cnt=0,1,2, o_z_id=2, o_z_last only at T3. o_a_r[2] pulses at T3.
- All four requesting continuously, cnt=2 each. Grant order 0,1,2,3,0. Each burst has exactly 2 beats. There is a 1-cycle gap between bursts (macro off) or none (macro on).
- Backpressure: cnt=4, i_z_r toggled 1,0,0,1,1,0,1. o_z_cnt advances only on handshake cycles. Exactly 4 transfers; o_a_r pulses only with the 4th.
- Zero count: requester 1 cnt=0 and requester 3 cnt=1. Requester 1 is accepted with no z beat and no o_a_r[1]. Requester 3 then gets 1 beat with o_z_last=1.
- Data stall plus reset: cnt=5, i_a_v drops after beat 2. o_z_v=0 and cnt holds at 2. Assert reset mid-burst: all outputs 0. After release, requester 0 wins first (ptr=0).
- Max count, W=4: cnt=15. Exactly 15 beats, o_z_cnt runs 0..14, last asserted at 14, no early wrap.
